// File: rtl/acc_delta.sv
// acc_delta: recovers the increment stream x[n] = q[n] - q[n-1] (mod 2^WIDTH)
// from a stream of accumulated values.
// Accepted samples are decoded in the input cycle and buffered in an output
// FIFO, so downstream stalls never drop a sample.
// in_ready depends only on registered FIFO state.
module acc_delta #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_q,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [31:0]      count
);

  localparam int AW = $clog2(DEPTH);

  // Modular difference; two's-complement wrap is the intended behaviour.
  function automatic logic signed [WIDTH-1:0] wrap_sub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return a - b;
  endfunction

  logic signed [WIDTH-1:0] prev;
  logic signed [WIDTH-1:0] x_p0;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [WIDTH-1:0]        last_x;
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A sequence start ignores the predecessor.
  assign x_p0 = in_first ? $signed(in_q) : wrap_sub($signed(in_q), prev);

  // Stage p0 -> FIFO: the decoded increment is written at the tail.
  // Only data is stored here, so this block has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= x_p0;
    end
  end

  // Pointer, predecessor, sample counter and last popped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      prev   <= '0;
      count  <= '0;
      last_x <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        prev   <= $signed(in_q);
        count  <= count + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_x <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // The head entry is shown while the FIFO is non-empty.
  // Otherwise the last popped value is held.
  assign out_x = empty ? last_x : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_acc_delta.sv
// Scoreboard bench for acc_delta.
// Inputs are driven 1 ns after the rising edge; the DUT is observed on the
// falling edge.
module tb_acc_delta;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_q = '0;
  logic             in_first = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_x;
  logic [31:0]      count;

  int checks = 0;
  int failures = 0;

  logic [31:0] sb [$];
  logic [31:0] got [$];
  logic [31:0] m_prev = '0;
  logic [31:0] m_count = '0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_x = '0;

  acc_delta #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_q      (in_q),
    .in_first  (in_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_got(input string tag, input int i, input logic [31:0] e);
    if (i < got.size()) check(tag, got[i], e);
    else check({tag, "_missing"}, got.size(), i + 1);
  endtask

  // Monitor: state checks first, then pop/compare, then model the push.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_count", count, 32'd0);
      check("rst_x", out_x, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      sb.delete();
      m_prev = '0;
      m_count = '0;
      hold_v = 1'b0;
    end else begin
      check("valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      check("ready", {31'd0, in_ready}, {31'd0, sb.size() < DEPTH});
      check("count", count, m_count);
      if (hold_v && out_valid) check("stable", out_x, hold_x);
      if (out_valid && out_ready && sb.size() > 0) begin
        check("x", out_x, sb.pop_front());
        got.push_back(out_x);
      end
      hold_v = out_valid && !out_ready;
      hold_x = out_x;
      if (in_valid && in_ready) begin
        sb.push_back(in_first ? in_q : in_q - m_prev);
        m_prev = in_q;
        m_count = m_count + 32'd1;
      end
    end
  end

  task automatic send(input logic [31:0] q, input logic first);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_q = q;
    in_first = first;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (out_valid) check("drain_timeout", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: basic decode, one-cycle latency
    out_ready = 1'b1;
    got.delete();
    send(32'd0, 1'b0);
    send(32'd1, 1'b0);
    send(32'd3, 1'b0);
    send(32'd6, 1'b0);
    send(32'd10, 1'b0);
    drain();
    check("t1_count", count, 32'd5);
    for (int i = 0; i < 5; i++) check_got("t1_x", i, i);

    // 2: wrapping subtraction
    got.delete();
    send(32'hFFFF_FFFE, 1'b1);
    send(32'h0000_0003, 1'b0);
    drain();
    check_got("t2_x0", 0, 32'hFFFF_FFFE);
    check_got("t2_x1", 1, 32'd5);

    // 3: backpressure, six offers into a four-entry FIFO
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_q = 32'd100 + 32'(i) * 32'd10;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("t3_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_ready_back", {31'd0, in_ready}, 32'd1);
    drain();
    check_got("t3_x0", 0, 32'd97);
    check_got("t3_x1", 1, 32'd10);
    check_got("t3_x2", 2, 32'd10);
    check_got("t3_x3", 3, 32'd10);
    check("t3_n", got.size(), 32'd4);

    // 4: sequence restart via in_first
    got.delete();
    send(32'd10, 1'b1);
    send(32'd15, 1'b0);
    send(32'd7, 1'b1);
    send(32'd9, 1'b0);
    drain();
    check_got("t4_x0", 0, 32'd10);
    check_got("t4_x1", 1, 32'd5);
    check_got("t4_x2", 2, 32'd7);
    check_got("t4_x3", 3, 32'd2);

    // 5: simultaneous push/pop at occupancy 2
    got.delete();
    out_ready = 1'b0;
    send(32'd200, 1'b1);
    send(32'd201, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_q = 32'd205 + 32'(i) * 32'd3;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    check("t5_n", got.size(), 32'd10);
    check_got("t5_x0", 0, 32'd200);
    check_got("t5_x1", 1, 32'd1);
    check_got("t5_x2", 2, 32'd4);
    for (int i = 3; i < 10; i++) check_got("t5_xn", i, 32'd3);

    // 6: reset with entries queued
    out_ready = 1'b0;
    send(32'd300, 1'b0);
    send(32'd301, 1'b0);
    send(32'd302, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_count", count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    out_ready = 1'b1;
    send(32'd20, 1'b0);
    drain();
    check_got("t6_x", 0, 32'd20);
    check("t6_count_after", count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
